// File: rtl/lif_step_scheduler_pkg.sv
// Shared types and reset constants for the LIF step scheduler.
// Potentials and config words are Q16.16 signed 32-bit values.
package lif_step_scheduler_pkg;

    typedef logic signed [31:0] fixed_t;

    localparam logic [31:0] VTH_DEF  = 32'h0000FC93;
    localparam logic [31:0] LEAK_DEF = 32'h00002000;
    localparam logic [31:0] W_DEF    = 32'h00002000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] CFG_VTH  = 2'd0;
    localparam logic [1:0] CFG_LEAK = 2'd1;
    localparam logic [1:0] CFG_W    = 2'd2;

    function automatic fixed_t sat32(input logic signed [39:0] x);
        if (x > 40'sh007FFFFFFF)
            return 32'sh7FFFFFFF;
        else if (x < -40'sh0080000000)
            return 32'sh80000000;
        else
            return x[31:0];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF update: integrate or leak, threshold, refractory.
module lif_update_unit
    import lif_step_scheduler_pkg::*;
#(
    parameter int FANIN        = 8,
    parameter int REFRAC_STEPS = 1,
    parameter int RW           = 1
) (
    input  logic [31:0]      i_v,
    input  logic [RW-1:0]    i_refrac,
    input  logic [FANIN-1:0] i_inputs,
    input  logic [31:0]      i_vth,
    input  logic [31:0]      i_leak,
    input  logic [31:0]      i_w,
    output logic [31:0]      o_v_new,
    output logic [RW-1:0]    o_refrac_new,
    output logic             o_spike
);

    localparam int CW = $clog2(FANIN + 1);

    logic [CW-1:0]      w_cnt;
    logic signed [39:0] w_a;
    logic signed [39:0] w_sum;
    logic signed [39:0] w_dif;
    fixed_t             w_int;

    always_comb begin
        w_cnt = '0;
        for (int b = 0; b < FANIN; b++)
            w_cnt = w_cnt + CW'(i_inputs[b]);
    end

    // 40-bit products keep FANIN * max weight from wrapping before saturation.
    assign w_a   = $signed({{(40-CW){1'b0}}, w_cnt}) * $signed({{8{i_w[31]}}, i_w});
    assign w_sum = $signed({{8{i_v[31]}}, i_v}) + w_a;
    assign w_dif = $signed({{8{i_v[31]}}, i_v}) - $signed({{8{i_leak[31]}}, i_leak});

    always_comb begin
        w_int        = '0;
        o_v_new      = '0;
        o_refrac_new = '0;
        o_spike      = 1'b0;
        if (w_a > 40'sd0)
            w_int = sat32(w_sum);
        else if (w_dif < 40'sd0)
            w_int = '0;
        else
            w_int = sat32(w_dif);

        if (i_refrac != '0) begin
            o_refrac_new = i_refrac - RW'(1);
        end else if (w_int >= $signed(i_vth)) begin
            o_spike      = 1'b1;
            o_refrac_new = RW'(REFRAC_STEPS);
        end else begin
            o_v_new = w_int;
        end
    end

endmodule

// File: rtl/lif_step_scheduler.sv
// Walks one LIF update datapath across all neurons per accepted timestep and
// owns the runtime threshold/leak/weight configuration.
module lif_step_scheduler
    import lif_step_scheduler_pkg::*;
#(
    parameter int          NUM_NEURONS  = 4,
    parameter int          FANIN        = 8,
    parameter int          REFRAC_STEPS = 1,
    parameter logic [31:0] VTH_RST      = VTH_DEF,
    parameter logic [31:0] LEAK_RST     = LEAK_DEF,
    parameter logic [31:0] W_RST        = W_DEF,
    localparam int         IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_step_valid,
    output logic                         o_step_ready,
    input  logic [NUM_NEURONS*FANIN-1:0] i_in_spikes,
    input  logic                         i_cfg_we,
    input  logic [1:0]                   i_cfg_addr,
    input  logic [31:0]                  i_cfg_data,
    output logic                         o_cfg_err,
    output logic                         o_vout_valid,
    output logic [IW-1:0]                o_vout_idx,
    output logic [31:0]                  o_vout_data,
    output logic [NUM_NEURONS-1:0]       o_spike_out,
    output logic                         o_spike_valid,
    output logic [1:0]                   o_state
);

    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    // Handshake: a step is taken on any clock edge where i_step_valid && o_step_ready;
    // o_step_ready is high only in IDLE and i_in_spikes is sampled on that same edge.
    state_e                 r_state;
    logic [IW-1:0]          r_idx;
    logic [FANIN-1:0]       r_in [NUM_NEURONS];
    logic [31:0]            r_v [NUM_NEURONS];
    logic [RW-1:0]          r_ref [NUM_NEURONS];
    logic [31:0]            r_vth;
    logic [31:0]            r_leak;
    logic [31:0]            r_w;
    logic [NUM_NEURONS-1:0] r_shadow;
    logic                   r_step_ready;
    logic                   r_cfg_err;
    logic                   r_vout_valid;
    logic [IW-1:0]          r_vout_idx;
    logic [31:0]            r_vout_data;
    logic [NUM_NEURONS-1:0] r_spike_out;
    logic                   r_spike_valid;

    logic          w_accept;
    logic [31:0]   w_v_new;
    logic [RW-1:0] w_ref_new;
    logic          w_spike;

    assign w_accept = i_step_valid && r_step_ready;

    lif_update_unit #(
        .FANIN       (FANIN),
        .REFRAC_STEPS(REFRAC_STEPS),
        .RW          (RW)
    ) u_update (
        .i_v         (r_v[r_idx]),
        .i_refrac    (r_ref[r_idx]),
        .i_inputs    (r_in[r_idx]),
        .i_vth       (r_vth),
        .i_leak      (r_leak),
        .i_w         (r_w),
        .o_v_new     (w_v_new),
        .o_refrac_new(w_ref_new),
        .o_spike     (w_spike)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_vth         <= VTH_RST;
            r_leak        <= LEAK_RST;
            r_w           <= W_RST;
            r_shadow      <= '0;
            r_step_ready  <= 1'b1;
            r_cfg_err     <= 1'b0;
            r_vout_valid  <= 1'b0;
            r_vout_idx    <= '0;
            r_vout_data   <= '0;
            r_spike_out   <= '0;
            r_spike_valid <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_in[k]  <= '0;
                r_v[k]   <= '0;
                r_ref[k] <= '0;
            end
        end else begin
            r_cfg_err     <= 1'b0;
            r_vout_valid  <= 1'b0;
            r_spike_valid <= 1'b0;

            // Config only lands between steps so a running step sees one consistent set.
            if (i_cfg_we) begin
                if (r_state == IDLE) begin
                    case (i_cfg_addr)
                        CFG_VTH:  r_vth  <= i_cfg_data;
                        CFG_LEAK: r_leak <= i_cfg_data;
                        CFG_W:    r_w    <= i_cfg_data;
                        default:  ;
                    endcase
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < NUM_NEURONS; k++)
                            r_in[k] <= i_in_spikes[k*FANIN +: FANIN];
                        r_idx        <= '0;
                        r_shadow     <= '0;
                        r_step_ready <= 1'b0;
                        r_state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_v[r_idx]      <= w_v_new;
                    r_ref[r_idx]    <= w_ref_new;
                    r_shadow[r_idx] <= w_spike;
                    r_vout_valid    <= 1'b1;
                    r_vout_idx      <= r_idx;
                    r_vout_data     <= w_v_new;
                    if (r_idx == IW'(NUM_NEURONS - 1))
                        r_state <= DONE;
                    else
                        r_idx <= r_idx + IW'(1);
                end
                DONE: begin
                    r_spike_out   <= r_shadow;
                    r_spike_valid <= 1'b1;
                    r_step_ready  <= 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_step_ready  = r_step_ready;
    assign o_cfg_err     = r_cfg_err;
    assign o_vout_valid  = r_vout_valid;
    assign o_vout_idx    = r_vout_idx;
    assign o_vout_data   = r_vout_data;
    assign o_spike_out   = r_spike_out;
    assign o_spike_valid = r_spike_valid;
    assign o_state       = r_state;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler with hand-computed expected values.
module tb_lif_step_scheduler;

    localparam int N = 4;
    localparam int F = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_valid;
    logic          step_ready;
    logic [N*F-1:0] in_spikes;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic          cfg_err;
    logic          vout_valid;
    logic [1:0]    vout_idx;
    logic [31:0]   vout_data;
    logic [N-1:0]  spike_out;
    logic          spike_valid;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;

    logic [31:0] v_obs [N];
    logic [N-1:0] spk_obs;
    int          sv_cyc;
    int          vcnt;
    logic        err1;
    logic        err2;

    always #5 clk = ~clk;

    lif_step_scheduler #(
        .NUM_NEURONS (N),
        .FANIN       (F),
        .REFRAC_STEPS(1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_step_valid (step_valid),
        .o_step_ready (step_ready),
        .i_in_spikes  (in_spikes),
        .i_cfg_we     (cfg_we),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_data   (cfg_data),
        .o_cfg_err    (cfg_err),
        .o_vout_valid (vout_valid),
        .o_vout_idx   (vout_idx),
        .o_vout_data  (vout_data),
        .o_spike_out  (spike_out),
        .o_spike_valid(spike_valid),
        .o_state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("cfg_err_idle", 32'(cfg_err), 32'd0);
    endtask

    // Runs one timestep; optional config write on the accept edge (same_we) or
    // one cycle into the update (cfg_mid). Collects per-neuron vout and spike result.
    task automatic run_step(input logic [31:0] spk, input logic cfg_mid, input logic same_we,
                            input logic [1:0] same_addr, input logic [31:0] same_data);
        int waited;
        waited = 0;
        for (int k = 0; k < N; k++) v_obs[k] = 32'hDEADBEEF;
        spk_obs = '0;
        sv_cyc  = 0;
        vcnt    = 0;
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = spk;
        cfg_we     = same_we;
        cfg_addr   = same_addr;
        cfg_data   = same_data;
        while (!step_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 32'(waited >= 20), 32'd0);
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        in_spikes  = $urandom;
        cfg_we     = 1'b0;
        if (cfg_mid) begin
            cfg_we   = 1'b1;
            cfg_addr = 2'd0;
            cfg_data = 32'h00001000;
        end
        for (int c = 1; c <= N + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                err1   = cfg_err;
                cfg_we = 1'b0;
            end
            if (c == 2) err2 = cfg_err;
            if (c == N) chk("ready_busy", 32'(step_ready), 32'd0);
            if (vout_valid) begin
                vcnt++;
                chk("vout_idx", 32'(vout_idx), 32'(c - 1));
                v_obs[vout_idx] = vout_data;
            end
            if (spike_valid && sv_cyc == 0) begin
                sv_cyc  = c;
                spk_obs = spike_out;
            end
        end
        chk("vout_count", 32'(vcnt), 32'(N));
        chk("spike_valid_cycle", 32'(sv_cyc), 32'(N + 1));
        chk("ready_after_done", 32'(step_ready), 32'd1);
    endtask

    task automatic step(input logic [31:0] spk);
        run_step(spk, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] n2_exp [7];
        logic [N-1:0] n0_spk [3];
        int pulses;
        int p1;
        int p2;

        n2_exp = '{32'h6000 - 32'h4000, 32'h4000, 32'h6000, 32'h4000, 32'h2000, 32'h0, 32'h0};
        n2_exp[0] = 32'h2000;
        n0_spk = '{4'b0001, 4'b0000, 4'b0001};

        rst_n      = 1'b0;
        step_valid = 1'b0;
        in_spikes  = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;

        // Reset release with no step requested
        repeat (2) @(negedge clk);
        chk("ready_in_reset", 32'(step_ready), 32'd1);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (spike_valid || vout_valid || cfg_err) pulses++;
        end
        chk("reset_no_pulses", 32'(pulses), 32'd0);
        chk("reset_ready", 32'(step_ready), 32'd1);
        chk("reset_spike_out", 32'(spike_out), 32'd0);
        chk("reset_state", 32'(state), 32'd0);

        // Neuron0 all inputs: 8*0.125 = 1.0 >= 0.98 fires
        step(32'h000000FF);
        for (int k = 0; k < N; k++) chk("n0_fire_v", v_obs[k], 32'h0);
        chk("n0_fire_spk", 32'(spk_obs), 32'h1);

        // Neuron1 one input per step: ramps by 0x2000, fires on the 8th
        for (int i = 1; i <= 8; i++) begin
            step(32'h00000100);
            chk("n1_ramp_v", v_obs[1], (i < 8) ? 32'(i * 32'h2000) : 32'h0);
            chk("n1_ramp_spk", 32'(spk_obs), (i == 8) ? 32'h2 : 32'h0);
            if (i == 1) chk("n0_refrac_v", v_obs[0], 32'h0);
        end

        // Neuron2 up to 0x6000, then leaks down and clamps at 0
        for (int i = 0; i < 7; i++) begin
            step((i < 3) ? 32'h00010000 : 32'h0);
            chk("n2_leak_v", v_obs[2], n2_exp[i]);
            chk("n2_leak_spk", 32'(spk_obs), 32'h0);
        end

        // Neuron0 driven three steps: fire, refractory, fire
        for (int i = 0; i < 3; i++) begin
            step(32'h000000FF);
            chk("n0_refrac_spk", 32'(spk_obs), 32'(n0_spk[i]));
            chk("n0_refrac_v0", v_obs[0], 32'h0);
        end

        // Weight written on the accept edge applies to that step
        run_step(32'h01000000, 1'b0, 1'b1, 2'd2, 32'h00004000);
        chk("same_cycle_w_v3", v_obs[3], 32'h4000);
        chk("same_cycle_w_v0", v_obs[0], 32'h0);
        cfg_write(2'd3, 32'h12345678);
        cfg_write(2'd2, 32'h00002000);

        // Back-to-back steps with step_valid held high
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = '0;
        @(posedge clk);
        #1;
        pulses = 0;
        p1 = 0;
        p2 = 0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            if (spike_valid) begin
                pulses++;
                if (pulses == 1) p1 = c;
                if (pulses == 2) p2 = c;
            end
            if (c == 11) step_valid = 1'b0;
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first", 32'(p1), 32'd5);
        chk("b2b_second", 32'(p2), 32'd11);

        // Reset asserted while neuron 2 is being updated
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = 32'h01010101;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid_state_update", 32'(state), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(step_ready), 32'd1);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_vout_valid", 32'(vout_valid), 32'd0);
        chk("mid_rst_spike_out", 32'(spike_out), 32'd0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (spike_valid || vout_valid) pulses++;
        end
        chk("mid_rst_no_pulses", 32'(pulses), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Potentials cleared; config write during the step is dropped with an error pulse
        run_step(32'h01010101, 1'b1, 1'b0, 2'd0, 32'd0);
        for (int k = 0; k < N; k++) chk("post_rst_v", v_obs[k], 32'h2000);
        chk("cfg_err_pulse", 32'(err1), 32'd1);
        chk("cfg_err_clear", 32'(err2), 32'd0);

        // 0x2000 + 6*0x2000 = 0xE000 stays below the untouched 0xFC93 threshold
        step(32'h0000003F);
        chk("vth_kept_v0", v_obs[0], 32'hE000);
        chk("vth_kept_v1", v_obs[1], 32'h0);
        chk("vth_kept_spk", 32'(spk_obs), 32'h0);

        // Saturation: 0x40000000 + 0x40000000 clamps to 0x7FFFFFFF which meets Vth
        cfg_write(2'd0, 32'h7FFFFFFF);
        cfg_write(2'd1, 32'h00002000);
        cfg_write(2'd2, 32'h40000000);
        step(32'h00000100);
        chk("sat_first_v1", v_obs[1], 32'h40000000);
        chk("sat_first_v0", v_obs[0], 32'hC000);
        chk("sat_first_spk", 32'(spk_obs), 32'h0);
        step(32'h00000100);
        chk("sat_fire_v1", v_obs[1], 32'h0);
        chk("sat_fire_v0", v_obs[0], 32'hA000);
        chk("sat_fire_spk", 32'(spk_obs), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
